// File: rtl/dmem_arbiter_if.sv
// Request/grant and RAM-side bundle for the shared 256x16 data memory.
// slave = arbiter view; master = requester/RAM view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;
    logic              c_stall;

    logic              h_req;
    logic              h_we;
    logic              h_lock;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_gnt;
    logic              h_rvalid;
    logic [DATA_W-1:0] h_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata, c_stall,
        input  h_req, h_we, h_lock, h_addr, h_wdata,
        output h_gnt, h_rvalid, h_rdata,
        output mem_addr, mem_wr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata, c_stall,
        output h_req, h_we, h_lock, h_addr, h_wdata,
        input  h_gnt, h_rvalid, h_rdata,
        input  mem_addr, mem_wr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between CPU (C) and host loader (H).
// Latency: grant/issue same cycle (combinational), read data returned the cycle after the grant.
// Backpressure: loser sees gnt=0 and holds its request; c_stall freezes the control FSM.
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_LOCK = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

    typedef enum logic {S_ARB, S_LOCK} state_t;
    typedef enum logic {OWN_C, OWN_H} owner_t;

    state_t            state, state_nxt;
    owner_t            last_owner, owner_nxt;
    logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
    logic              lock_hold;
    logic              h_gnt, c_gnt;
    logic              rd_vld, rd_owner;
    logic [DATA_W-1:0] c_rdata_q, h_rdata_q;

    always_comb begin
        state_nxt    = S_ARB;
        lock_cnt_nxt = '0;
        owner_nxt    = last_owner;
        // Host keeps the RAM only while it still asks for both access and lock.
        lock_hold = (state == S_LOCK) && bus.h_req && bus.h_lock;
        h_gnt = rst_n && bus.h_req &&
                (lock_hold || !bus.c_req || (last_owner == OWN_C));
        c_gnt = rst_n && bus.c_req && !h_gnt;

        if (h_gnt) begin
            owner_nxt = OWN_H;
            if (lock_hold) begin
                if (lock_cnt + CNT_W'(1) < MAX_CNT) begin
                    state_nxt    = S_LOCK;
                    lock_cnt_nxt = lock_cnt + CNT_W'(1);
                end
            end else if (bus.h_lock) begin
                state_nxt    = S_LOCK;
                lock_cnt_nxt = CNT_W'(1);
            end
        end else if (c_gnt) begin
            owner_nxt = OWN_C;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_ARB;
            last_owner <= OWN_C;
            lock_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= owner_nxt;
            lock_cnt   <= lock_cnt_nxt;
        end
    end

    // Read return pipeline runs independently of arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld    <= 1'b0;
            rd_owner  <= 1'b0;
            c_rdata_q <= '0;
            h_rdata_q <= '0;
        end else begin
            rd_vld   <= (h_gnt && !bus.h_we) || (c_gnt && !bus.c_we);
            rd_owner <= h_gnt;
            if (rd_vld && rd_owner)  h_rdata_q <= bus.mem_rdata;
            if (rd_vld && !rd_owner) c_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.h_gnt    = h_gnt;
    assign bus.c_gnt    = c_gnt;
    assign bus.c_stall  = bus.c_req && !c_gnt;
    assign bus.h_rvalid = rd_vld && rd_owner;
    assign bus.c_rvalid = rd_vld && !rd_owner;
    assign bus.h_rdata  = bus.h_rvalid ? bus.mem_rdata : h_rdata_q;
    assign bus.c_rdata  = bus.c_rvalid ? bus.mem_rdata : c_rdata_q;

    assign bus.mem_addr  = h_gnt ? bus.h_addr  : (c_gnt ? bus.c_addr  : '0);
    assign bus.mem_wdata = h_gnt ? bus.h_wdata : (c_gnt ? bus.c_wdata : '0);
    assign bus.mem_wr    = (h_gnt && bus.h_we) || (c_gnt && bus.c_we);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered 256x16 RAM model on the memory side.
module tb_dmem_arbiter;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [15:0] ram [256];

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_LOCK(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.c_req = 0; bus.c_we = 0; bus.h_req = 0; bus.h_we = 0; bus.h_lock = 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 0;
        bus.mem_rdata = '0;
        bus.c_wdata = '0; bus.h_wdata = '0;
        bus.c_we = 0; bus.h_we = 0; bus.h_lock = 0;
        bus.c_req = 1; bus.h_req = 1;
        bus.c_addr = 8'h20; bus.h_addr = 8'h10;

        // Reset with both requesting
        @(negedge clk);
        check_eq("rst_h_gnt", bus.h_gnt, 0);
        check_eq("rst_c_gnt", bus.c_gnt, 0);
        check_eq("rst_h_rvalid", bus.h_rvalid, 0);
        check_eq("rst_c_rvalid", bus.c_rvalid, 0);
        next_cyc;
        rst_n = 1;
        @(negedge clk);
        check_eq("rr1_h_gnt", bus.h_gnt, 1);
        check_eq("rr1_c_gnt", bus.c_gnt, 0);
        check_eq("rr1_addr", bus.mem_addr, 8'h10);
        next_cyc;
        @(negedge clk);
        check_eq("rr2_c_gnt", bus.c_gnt, 1);
        check_eq("rr2_h_gnt", bus.h_gnt, 0);
        check_eq("rr2_addr", bus.mem_addr, 8'h20);
        check_eq("rr2_h_rvalid", bus.h_rvalid, 1);
        next_cyc;
        @(negedge clk);
        check_eq("rr3_h_gnt", bus.h_gnt, 1);
        check_eq("rr3_c_rvalid", bus.c_rvalid, 1);
        next_cyc;
        @(negedge clk);
        check_eq("rr4_c_gnt", bus.c_gnt, 1);
        next_cyc;
        idle;
        @(negedge clk);
        check_eq("idle_gnt", {bus.h_gnt, bus.c_gnt, bus.mem_wr}, 0);
        check_eq("idle_addr", bus.mem_addr, 0);
        check_eq("idle_wdata", bus.mem_wdata, 0);
        next_cyc;

        // Preload through the arbiter: C writes 02, H writes 01
        bus.c_req = 1; bus.c_we = 1; bus.c_addr = 8'h02; bus.c_wdata = 16'h5555;
        @(negedge clk);
        check_eq("pre_c_gnt", bus.c_gnt, 1);
        next_cyc;
        idle;
        bus.h_req = 1; bus.h_we = 1; bus.h_addr = 8'h01; bus.h_wdata = 16'hAAAA;
        @(negedge clk);
        check_eq("pre_h_gnt", bus.h_gnt, 1);
        check_eq("pre_h_wr", bus.mem_wr, 1);
        check_eq("pre_h_wdata", bus.mem_wdata, 16'hAAAA);
        next_cyc;
        idle;
        next_cyc;

        // CPU alone: write then read 0xBC
        bus.c_req = 1; bus.c_we = 1; bus.c_addr = 8'hBC; bus.c_wdata = 16'h1234;
        @(negedge clk);
        check_eq("cw_gnt", bus.c_gnt, 1);
        check_eq("cw_wr", bus.mem_wr, 1);
        check_eq("cw_stall", bus.c_stall, 0);
        next_cyc;
        bus.c_we = 0;
        @(negedge clk);
        check_eq("cr_gnt", bus.c_gnt, 1);
        check_eq("cr_wr", bus.mem_wr, 0);
        check_eq("cr_stall", bus.c_stall, 0);
        check_eq("cw_no_rvalid", bus.c_rvalid, 0);
        next_cyc;
        idle;
        @(negedge clk);
        check_eq("cr_rvalid", bus.c_rvalid, 1);
        check_eq("cr_rdata", bus.c_rdata, 16'h1234);
        check_eq("cr_h_rvalid", bus.h_rvalid, 0);
        check_eq("cr_stall_idle", bus.c_stall, 0);
        next_cyc;

        // Full host lock burst: 8 host grants, then CPU
        bus.h_req = 1; bus.h_lock = 1; bus.h_addr = 8'h30;
        bus.c_req = 1; bus.c_addr = 8'h40;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq($sformatf("lock_h_gnt%0d", i), bus.h_gnt, 1);
            check_eq($sformatf("lock_c_stall%0d", i), bus.c_stall, 1);
            next_cyc;
        end
        @(negedge clk);
        check_eq("lock_end_c_gnt", bus.c_gnt, 1);
        check_eq("lock_end_h_gnt", bus.h_gnt, 0);
        next_cyc;
        idle;
        next_cyc;

        // Early lock release after 3 grants, then a fresh lock counts from 1
        bus.h_req = 1; bus.h_lock = 1; bus.c_req = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("early_h_gnt%0d", i), bus.h_gnt, 1);
            next_cyc;
        end
        bus.h_lock = 0;
        @(negedge clk);
        check_eq("early_c_gnt", bus.c_gnt, 1);
        check_eq("early_h_gnt_off", bus.h_gnt, 0);
        next_cyc;
        bus.c_req = 0; bus.h_lock = 1;
        @(negedge clk);
        check_eq("relock_h_gnt0", bus.h_gnt, 1);
        next_cyc;
        bus.c_req = 1;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check_eq($sformatf("relock_h_gnt%0d", i), bus.h_gnt, 1);
            next_cyc;
        end
        @(negedge clk);
        check_eq("relock_c_gnt", bus.c_gnt, 1);
        next_cyc;
        idle;
        next_cyc;

        // Interleaved reads H@01 then C@02
        bus.h_req = 1; bus.h_addr = 8'h01;
        @(negedge clk);
        check_eq("ir_h_gnt", bus.h_gnt, 1);
        next_cyc;
        idle;
        bus.c_req = 1; bus.c_addr = 8'h02;
        @(negedge clk);
        check_eq("ir_c_gnt", bus.c_gnt, 1);
        check_eq("ir_h_rvalid", bus.h_rvalid, 1);
        check_eq("ir_h_rdata", bus.h_rdata, 16'hAAAA);
        check_eq("ir_c_rvalid0", bus.c_rvalid, 0);
        next_cyc;
        idle;
        @(negedge clk);
        check_eq("ir_c_rvalid", bus.c_rvalid, 1);
        check_eq("ir_c_rdata", bus.c_rdata, 16'h5555);
        check_eq("ir_h_rvalid0", bus.h_rvalid, 0);
        check_eq("ir_h_rdata_hold", bus.h_rdata, 16'hAAAA);
        next_cyc;
        @(negedge clk);
        check_eq("ir_c_rvalid_off", bus.c_rvalid, 0);
        check_eq("ir_c_rdata_hold", bus.c_rdata, 16'h5555);
        next_cyc;

        // Reset right after a host read grant
        bus.h_req = 1; bus.h_addr = 8'h01;
        @(negedge clk);
        check_eq("rr_h_gnt", bus.h_gnt, 1);
        next_cyc;
        rst_n = 0;
        bus.c_req = 1; bus.c_addr = 8'h20; bus.h_addr = 8'h10;
        @(negedge clk);
        check_eq("rr_h_rvalid", bus.h_rvalid, 0);
        check_eq("rr_h_rdata", bus.h_rdata, 0);
        check_eq("rr_gnts", {bus.h_gnt, bus.c_gnt}, 0);
        next_cyc;
        rst_n = 1;
        @(negedge clk);
        check_eq("rr_post_h_gnt", bus.h_gnt, 1);
        check_eq("rr_post_c_gnt", bus.c_gnt, 0);
        check_eq("rr_post_rvalid", {bus.h_rvalid, bus.c_rvalid}, 0);
        next_cyc;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256x16 data memory between two requesters: the processor control unit (port C) and a host/debug loader (port H).
- Sits between the FSM/datapath memory signals and the RAM.
- Round-robin arbitration with single-cycle issue and 1-cycle read return; the host may lock the memory for a bounded burst.
- Exports a stall signal so the control FSM holds its current state while it waits.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 16, memory data width.
- MAX_LOCK, 8, maximum consecutive host grants while h_lock is high; minimum 2.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- c_req  in  1  CPU access request; held until granted.
- c_we  in  1  CPU write enable (1 = write, 0 = read).
- c_addr  in  ADDR_W  CPU address.
- c_wdata  in  DATA_W  CPU write data.
- c_gnt  out  1  CPU access issued this cycle.
- c_rvalid  out  1  CPU read data valid.
- c_rdata  out  DATA_W  CPU read data.
- c_stall  out  1  c_req & ~c_gnt.
- h_req  in  1  host access request.
- h_we  in  1  host write enable.
- h_lock  in  1  host requests back-to-back ownership.
- h_addr  in  ADDR_W  host address.
- h_wdata  in  DATA_W  host write data.
- h_gnt  out  1  host access issued this cycle.
- h_rvalid  out  1  host read data valid.
- h_rdata  out  DATA_W  host read data.
- mem_addr  out  ADDR_W  RAM address.
- mem_wr  out  1  RAM write strobe.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, registered, 1-cycle latency.

Behaviour:
- Reset (Reset=0, async):
  - last_owner=C, so H wins the first tie.
  - lock_cnt=0; state=ARB.
  - c_rvalid=h_rvalid=0; rd_owner pipeline flag cleared.
  - Combinational outputs with no requests: gnt=0, mem_wr=0, mem_addr=0, mem_wdata=0; rdata=0.
- Grants and mem_* are combinational from the current requests and registered state.
  - A transaction issues at the rising edge where gnt=1.
  - At most one gnt is high per cycle.
  - mem_* always carries the winner's fields; mem_wr = winner_we & gnt.
- State ARB:
  - Only one requester active: that requester is granted.
  - Both active: grant the port that is not last_owner.
  - On each grant edge: last_owner <= winner.
  - If the winner is H with h_lock=1, go to LOCK with lock_cnt=1.
- State LOCK (host owns the memory):
  - h_gnt = h_req; c_gnt = 0.
  - Each host grant increments lock_cnt.
  - Exit to ARB when any of these holds: h_lock=0, h_req=0, or lock_cnt reaches MAX_LOCK.
  - On exit, last_owner=H, so a pending CPU request wins next.
  - CPU worst-case wait = MAX_LOCK+1 cycles.
- Reads:
  - A read granted at edge N latches rd_owner.
  - During cycle N+1, the owner's rvalid=1 and its rdata=mem_rdata.
  - The other port's rdata is held at its last value.
  - Back-to-back reads give rvalid every cycle.
  - A write grant produces no rvalid.
- Simultaneous read return and new grant: allowed; the pipeline is independent of arbitration.
- Write then read to the same address on consecutive cycles: the read returns the new data, because the RAM writes at edge N.
- Reset asserted mid-burst or with a read in flight:
  - Pending rvalid is dropped and LOCK is aborted.
  - Requesters must reissue after reset.
- c_stall is purely combinational, for the FSM state-hold.
- Requests must not change fields while req=1 and gnt=0. Changing them is undefined and is not checked.

Test Plan:
- Reset=0 with h_req=c_req=1 -> all gnt/rvalid 0. After release, first cycle h_gnt=1 (tie goes to H), next cycle c_gnt=1, then alternating H,C,H,C.
- CPU alone: write addr 8'hBC data 16'h1234, then read 8'hBC -> c_gnt=1 on both, c_rvalid=1 one cycle after the read grant, c_rdata=16'h1234, c_stall=0 throughout.
- Host lock with MAX_LOCK=8: h_lock=1, h_req=1, c_req=1 -> 8 consecutive h_gnt, c_stall=1 for 8 cycles, then c_gnt=1 on the 9th.
- Host lock released early: h_lock drops after 3 grants -> next cycle c_gnt=1; lock_cnt restarts at 1 on the next lock.
- Interleaved reads: H reads 8'h01 (preloaded 16'hAAAA), C reads 8'h02 (16'h5555) on consecutive cycles -> h_rvalid then c_rvalid on consecutive cycles with the correct data, never both in the same cycle.
- Reset asserted the cycle after a read grant -> no rvalid appears; after release, arbitration restarts with H winning the tie.
